// File: rtl/hazard_control_unit_pkg.sv
// Shared types and constants for the hazard control unit.
// FSM state encoding, register index width and the NOP opcode.
package hazard_control_unit_pkg;

  localparam int REG_IDX_W_DEF = 5;
  localparam logic [3:0] NOP_OPC = 4'b0000;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } hcu_state_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// In-flight destination tracker: entry0=EX, entry1=MEM, entry2=WB.
// Flags a RAW hazard when a live source matches any valid entry.
module hazard_scoreboard #(
  parameter int SB_DEPTH  = 3,
  parameter int REG_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 shift_en_i,
  input  logic                 push_valid_i,
  input  logic [REG_IDX_W-1:0] push_idx_i,
  input  logic [REG_IDX_W-1:0] rs1_i,
  input  logic                 rs1_use_i,
  input  logic [REG_IDX_W-1:0] rs2_i,
  input  logic                 rs2_use_i,
  output logic                 hazard_o
);

  logic [SB_DEPTH-1:0]                vld_q, vld_d;
  logic [SB_DEPTH-1:0][REG_IDX_W-1:0] idx_q, idx_d;
  logic                               rs1_live;
  logic                               rs2_live;

  always_comb begin
    vld_d = vld_q;
    idx_d = idx_q;
    if (shift_en_i) begin
      vld_d[0] = push_valid_i;
      idx_d[0] = push_valid_i ? push_idx_i : '0;
      for (int k = 1; k < SB_DEPTH; k++) begin
        vld_d[k] = vld_q[k-1];
        idx_d[k] = idx_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      idx_q <= '0;
    end else begin
      vld_q <= vld_d;
      idx_q <= idx_d;
    end
  end

  // r0 is hardwired zero, so it can never be a true dependency
  assign rs1_live = rs1_use_i & (|rs1_i);
  assign rs2_live = rs2_use_i & (|rs2_i);

  always_comb begin
    hazard_o = 1'b0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      if (vld_q[k] &&
          ((rs1_live && idx_q[k] == rs1_i) ||
           (rs2_live && idx_q[k] == rs2_i)))
        hazard_o = 1'b1;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer: RAW stalls, mispredict flush, memory freeze.
// FSM, flush counter and saturating perf counters live here.
module hazard_control_unit #(
  parameter int SB_DEPTH     = 3,
  parameter int FLUSH_CYCLES = 2,
  parameter int REG_IDX_W    = 5,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] reg1_index_rf,
  input  logic [REG_IDX_W-1:0] reg2_index_rf,
  input  logic                 uses_reg1_id,
  input  logic                 uses_reg2_id,
  input  logic [REG_IDX_W-1:0] dest_reg_index_id,
  input  logic                 reg_write_id,
  input  logic                 mispredict_ex,
  input  logic                 mem_req_mem,
  input  logic                 mem_ready_mem,
  output logic                 stall_if,
  output logic                 bubble_id,
  output logic                 flush_if,
  output logic                 freeze_all,
  output logic [1:0]           state_o,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     flush_events
);

  import hazard_control_unit_pkg::*;

  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

  hcu_state_e       state_q, state_d;
  hcu_state_e       ret_q, ret_d;
  logic [FC_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic freeze;
  logic hazard;
  logic shift_en;
  logic push_valid;
  logic stall_c, bubble_c, flush_c;
  logic inc_stall, inc_flush;

  assign freeze = mem_req_mem & ~mem_ready_mem;

  hazard_scoreboard #(
    .SB_DEPTH  (SB_DEPTH),
    .REG_IDX_W (REG_IDX_W)
  ) u_sb (
    .clk          (clk),
    .rst_n        (rst_n),
    .shift_en_i   (shift_en),
    .push_valid_i (push_valid),
    .push_idx_i   (dest_reg_index_id),
    .rs1_i        (reg1_index_rf),
    .rs1_use_i    (uses_reg1_id),
    .rs2_i        (reg2_index_rf),
    .rs2_use_i    (uses_reg2_id),
    .hazard_o     (hazard)
  );

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    cnt_d      = cnt_q;
    stall_c    = 1'b0;
    bubble_c   = 1'b0;
    flush_c    = 1'b0;
    inc_stall  = 1'b0;
    inc_flush  = 1'b0;
    shift_en   = 1'b0;
    push_valid = 1'b0;
    unique case (state_q)
      RUN: begin
        if (freeze) begin
          state_d = MEM_WAIT;
          ret_d   = RUN;
        end else if (mispredict_ex) begin
          flush_c   = 1'b1;
          bubble_c  = 1'b1;
          cnt_d     = FC_W'(FLUSH_CYCLES);
          state_d   = FLUSH;
          inc_flush = 1'b1;
          shift_en  = 1'b1;
        end else if (hazard) begin
          stall_c   = 1'b1;
          bubble_c  = 1'b1;
          inc_stall = 1'b1;
          shift_en  = 1'b1;
        end else begin
          shift_en   = 1'b1;
          push_valid = reg_write_id & (|dest_reg_index_id);
        end
      end
      FLUSH: begin
        if (freeze) begin
          state_d = MEM_WAIT;
          ret_d   = FLUSH;
        end else begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
          shift_en = 1'b1;
          cnt_d    = cnt_q - FC_W'(1);
          if (cnt_q == FC_W'(1))
            state_d = RUN;
        end
      end
      MEM_WAIT: begin
        // release cycle lets the held ID instruction issue
        if (!freeze) begin
          state_d    = ret_q;
          shift_en   = 1'b1;
          push_valid = reg_write_id & (|dest_reg_index_id);
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (inc_stall && !(&stall_q))
      stall_d = stall_q + CNT_W'(1);
    if (inc_flush && !(&flush_q))
      flush_d = flush_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      ret_q   <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_if     = rst_n & stall_c;
  assign bubble_id    = ~rst_n | bubble_c;
  assign flush_if     = rst_n & flush_c;
  assign freeze_all   = rst_n & freeze;
  assign state_o      = state_q;
  assign stall_cycles = stall_q;
  assign flush_events = flush_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench: stimulus pushes model expectations, monitor compares.
// A narrow-counter second instance exercises saturation quickly.
module tb_hazard_control_unit;

  localparam int FC = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] r1 = '0, r2 = '0, dst = '0;
  logic       u1 = 1'b0, u2 = 1'b0, wr = 1'b0;
  logic       mis = 1'b0, mreq = 1'b0, mrdy = 1'b0;

  logic        stall_if, bubble_id, flush_if, freeze_all;
  logic [1:0]  state_o;
  logic [15:0] stall_cycles, flush_events;
  logic        s_stall_if, s_bubble_id, s_flush_if, s_freeze_all;
  logic [1:0]  s_state_o;
  logic [3:0]  s_stall_cycles, s_flush_events;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_control_unit dut (
    .clk(clk), .rst_n(rst_n),
    .reg1_index_rf(r1), .reg2_index_rf(r2),
    .uses_reg1_id(u1), .uses_reg2_id(u2),
    .dest_reg_index_id(dst), .reg_write_id(wr),
    .mispredict_ex(mis), .mem_req_mem(mreq), .mem_ready_mem(mrdy),
    .stall_if(stall_if), .bubble_id(bubble_id),
    .flush_if(flush_if), .freeze_all(freeze_all),
    .state_o(state_o),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  hazard_control_unit #(.CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .reg1_index_rf(r1), .reg2_index_rf(r2),
    .uses_reg1_id(u1), .uses_reg2_id(u2),
    .dest_reg_index_id(dst), .reg_write_id(wr),
    .mispredict_ex(mis), .mem_req_mem(mreq), .mem_ready_mem(mrdy),
    .stall_if(s_stall_if), .bubble_id(s_bubble_id),
    .flush_if(s_flush_if), .freeze_all(s_freeze_all),
    .state_o(s_state_o),
    .stall_cycles(s_stall_cycles), .flush_events(s_flush_events)
  );

  typedef struct {
    bit stall, bubble, flush, freeze;
    int state, sc, fe;
    int cyc;
  } exp_t;

  exp_t q[$];

  // reference: mode 0=RUN 1=FLUSH 2=MEM_WAIT
  int m_mode, m_ret, m_rem, m_sc, m_fe, cyc;
  int fl[$];

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic m_reset();
    m_mode = 0; m_ret = 0; m_rem = 0; m_sc = 0; m_fe = 0;
    fl = '{0, 0, 0};
  endtask

  task automatic step();
    exp_t e;
    bit frz, haz, adv;
    int push;
    e.stall = 0; e.bubble = 0; e.flush = 0; e.freeze = 0;
    e.cyc = cyc;
    if (!rst_n) begin
      m_reset();
      e.bubble = 1; e.state = 0; e.sc = 0; e.fe = 0;
      q.push_back(e);
      return;
    end
    e.state = m_mode; e.sc = m_sc; e.fe = m_fe;
    frz = mreq && !mrdy;
    e.freeze = frz;
    haz = 0;
    foreach (fl[k])
      if (fl[k] != 0 && ((u1 && fl[k] == int'(r1)) || (u2 && fl[k] == int'(r2))))
        haz = 1;
    adv = 0;
    push = 0;
    case (m_mode)
      0: begin
        if (frz) begin
          m_ret = 0; m_mode = 2;
        end else if (mis) begin
          e.flush = 1; e.bubble = 1;
          m_rem = FC; m_mode = 1; m_fe++; adv = 1;
        end else if (haz) begin
          e.stall = 1; e.bubble = 1; m_sc++; adv = 1;
        end else begin
          adv = 1; push = wr ? int'(dst) : 0;
        end
      end
      1: begin
        if (frz) begin
          m_ret = 1; m_mode = 2;
        end else begin
          e.flush = 1; e.bubble = 1; adv = 1;
          if (m_rem == 1) m_mode = 0;
          m_rem--;
        end
      end
      default: begin
        if (!frz) begin
          m_mode = m_ret; adv = 1;
          push = wr ? int'(dst) : 0;
        end
      end
    endcase
    if (adv) begin
      fl.push_front(push);
      void'(fl.pop_back());
    end
    q.push_back(e);
  endtask

  task automatic drv(bit rn, int a, bit ua, int b, bit ub,
                     int d, bit w, bit mp, bit mq, bit mr);
    @(posedge clk);
    #1;
    cyc++;
    rst_n = rn; r1 = 5'(a); u1 = ua; r2 = 5'(b); u2 = ub;
    dst = 5'(d); wr = w; mis = mp; mreq = mq; mrdy = mr;
    step();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("ctrl{stall,bubble,flush,freeze}",
              int'({stall_if, bubble_id, flush_if, freeze_all}),
              int'({e.stall, e.bubble, e.flush, e.freeze}));
        check("state_o", int'(state_o), e.state);
        check("stall_cycles", int'(stall_cycles), sat(e.sc, 16'hFFFF));
        check("flush_events", int'(flush_events), sat(e.fe, 16'hFFFF));
        check("sat_stall_cycles", int'(s_stall_cycles), sat(e.sc, 15));
        check("sat_flush_events", int'(s_flush_events), sat(e.fe, 15));
        check("sat_ctrl",
              int'({s_stall_if, s_bubble_id, s_flush_if, s_freeze_all, s_state_o}),
              int'({e.stall, e.bubble, e.flush, e.freeze, 2'(e.state)}));
      end
    end
  end

  initial begin : stim
    cyc = 0;
    m_reset();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // T1: reset mid-FLUSH, then a hazard-free stream
    drv(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i < 6; i++) drv(1, i, 1, i + 1, 1, i + 8, 1, 0, 0, 0);
    // T2: write r3 then read r3 -> 3 stalls
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) drv(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("t2_stall_cycles", int'(stall_cycles), 3);
    check("t2_issue_4th", int'(stall_if), 0);
    // T3: r0 and unused sources never stall
    drv(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    drv(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    drv(1, 3, 0, 3, 0, 0, 0, 0, 0, 0);
    // T4: mispredict while a hazard is pending
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    drv(1, 5, 1, 0, 0, 0, 0, 1, 0, 0);
    drv(1, 5, 1, 0, 0, 0, 0, 1, 0, 0);
    drv(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("t4_flush_events", int'(flush_events), 1);
    check("t4_no_stall", int'(stall_cycles), 0);
    check("t4_back_in_run", int'(state_o), 0);
    // T5: memory wait on first FLUSH cycle
    drv(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(4);
    // T6: hazard chain long enough to saturate the narrow counters
    for (int i = 0; i < 7; i++) begin
      drv(1, 4, 1, 0, 0, 4, 1, 0, 0, 0);
      for (int j = 0; j < 3; j++) drv(1, 4, 1, 0, 0, 4, 1, 0, 0, 0);
    end
    for (int i = 0; i < 20; i++) begin
      drv(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      idle(2);
    end
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit rq;
      rq = ($urandom_range(0, 99) < 15);
      drv(($urandom_range(0, 199) != 0),
          $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 7), 1'($urandom),
          $urandom_range(0, 7), ($urandom_range(0, 9) < 7),
          ($urandom_range(0, 9) == 0), rq, 1'($urandom));
    end
    idle(1);
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
